rr_priority_encoder: RTL and testbench

Parametrised, registered N-input priority encoder with sticky request capture and a valid/ready output handshake.
- Converts asynchronous-in-time request pulses into a stream of encoded indices, one per accepted handshake.
- Mode selects fixed priority (highest index wins) or round-robin priority.
- Sits between request sources (interrupt lines, channel service flags) and a single consumer that services one index at a time.

---
 rtl/rr_priority_encoder.sv | 142 ++++++++++++++
 tb/tb_rr_priority_encoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_priority_encoder.sv
// Registered N-input priority encoder with sticky request capture, fixed or
// round-robin selection, and a valid/ready grant handshake.
module rr_priority_encoder #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 mode,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [N-1:0]         out_onehot,
    output logic [N-1:0]         pending
);

    localparam int unsigned W = $clog2(N);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   onehot_q, onehot_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   ptr_q, ptr_d;

    logic           handshake;
    logic [N-1:0]   cand;
    logic [W-1:0]   idx_dec;
    logic [W-1:0]   ptr_sel;
    logic [W-1:0]   fix_idx;
    logic [W-1:0]   rr_idx;
    logic           rr_found;
    logic [W-1:0]   sel_idx;
    int             pos_i;

    assign handshake = (state_q == StBusy) && out_ready;

    // The granted bit is retired only when its handshake completes; a same-cycle
    // re-request on that bit is OR-ed back in so it is not lost.
    always_comb begin
        if (handshake) begin
            cand = (pending_q & ~onehot_q) | req;
        end else begin
            cand = pending_q | req;
        end
    end

    assign idx_dec = (idx_q == '0) ? W'(N - 1) : (idx_q - 1'b1);

    // On a round-robin handshake the next grant already sees the updated pointer.
    assign ptr_sel = (handshake && mode) ? idx_dec : ptr_q;

    always_comb begin
        fix_idx = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (cand[k]) begin
                fix_idx = W'(k);
            end
        end
    end

    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        pos_i    = 0;
        for (int k = 0; k < int'(N); k++) begin
            if (int'(ptr_sel) >= k) begin
                pos_i = int'(ptr_sel) - k;
            end else begin
                pos_i = int'(ptr_sel) + int'(N) - k;
            end
            if (!rr_found && cand[pos_i]) begin
                rr_found = 1'b1;
                rr_idx   = W'(pos_i);
            end
        end
    end

    assign sel_idx = mode ? rr_idx : fix_idx;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        onehot_d  = onehot_q;
        ptr_d     = ptr_q;
        pending_d = cand;

        if (handshake && mode) begin
            ptr_d = idx_dec;
        end

        unique case (state_q)
            StIdle: begin
                if (cand != '0) begin
                    idx_d    = sel_idx;
                    onehot_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (handshake) begin
                    if (cand != '0) begin
                        idx_d    = sel_idx;
                        onehot_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
                    end else begin
                        onehot_d = '0;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            onehot_q  <= '0;
            idx_q     <= '0;
            ptr_q     <= W'(N - 1);
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            onehot_q  <= onehot_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_valid  = (state_q == StBusy);
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed self-checking bench for rr_priority_encoder (N=8).
module tb_rr_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       mode;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic [7:0] pending;

    int n_cmp;
    int n_bad;

    rr_priority_encoder #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input string tag, input logic [2:0] idx);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
        chk({tag, "_onehot"}, 32'(out_onehot), 32'(8'd1 << idx));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;

        // Power-on reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("por_valid", 32'(out_valid), 32'd0);
        chk("por_idx", 32'(out_idx), 32'd0);
        chk("por_onehot", 32'(out_onehot), 32'd0);
        chk("por_pending", 32'(pending), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fixed-priority burst
        mode = 1'b0; out_ready = 1'b1; req = 8'h25;
        tick(); req = '0;
        grant("burst0", 3'd5);
        tick();
        grant("burst1", 3'd2);
        tick();
        grant("burst2", 3'd0);
        tick();
        chk("burst_idle_valid", 32'(out_valid), 32'd0);
        chk("burst_idle_onehot", 32'(out_onehot), 32'd0);
        chk("burst_idle_pending", 32'(pending), 32'd0);
        chk("burst_idle_idx_kept", 32'(out_idx), 32'd0);

        // Backpressure
        out_ready = 1'b0; req = 8'h08;
        tick(); req = '0;
        grant("bp0", 3'd3);
        req = 8'h80;
        tick(); req = '0;
        grant("bp_stall", 3'd3);
        chk("bp_pending", 32'(pending), 32'h88);
        out_ready = 1'b1;
        tick();
        grant("bp1", 3'd7);
        tick();
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_pending", 32'(pending), 32'd0);
        chk("bp_idle_idx_kept", 32'(out_idx), 32'd7);

        // Round-robin fairness on held requests
        mode = 1'b1; req = 8'h81;
        tick(); grant("rr0", 3'd7);
        tick(); grant("rr1", 3'd0);
        tick(); grant("rr2", 3'd7);
        tick(); grant("rr3", 3'd0);
        req = '0;
        tick(); grant("rr_drain", 3'd7);
        tick();
        chk("rr_idle_valid", 32'(out_valid), 32'd0);

        // Same stimulus, fixed priority starves bit 0 while bit 7 stays busy
        mode = 1'b0; req = 8'h81;
        tick(); grant("fx0", 3'd7);
        tick(); grant("fx1", 3'd7);
        tick(); grant("fx2", 3'd7);
        tick(); grant("fx3", 3'd7);
        req = '0;
        tick(); grant("fx_drain", 3'd0);
        tick();
        chk("fx_idle_valid", 32'(out_valid), 32'd0);
        chk("fx_idle_pending", 32'(pending), 32'd0);

        // Re-request on the handshake cycle
        out_ready = 1'b0; req = 8'h04;
        tick(); req = '0;
        grant("rereq0", 3'd2);
        out_ready = 1'b1; req = 8'h04;
        tick(); req = '0; out_ready = 1'b0;
        chk("rereq_pending", 32'(pending), 32'h04);
        grant("rereq1", 3'd2);
        out_ready = 1'b1;
        tick();
        chk("rereq_idle_valid", 32'(out_valid), 32'd0);
        chk("rereq_idle_pending", 32'(pending), 32'd0);

        // Mode flip and new requests while stalled
        out_ready = 1'b0; mode = 1'b0; req = 8'h81;
        tick(); req = '0;
        grant("mc0", 3'd7);
        mode = 1'b1;
        tick();
        grant("mc_stall0", 3'd7);
        req = 8'h40;
        tick(); req = '0;
        grant("mc_stall1", 3'd7);
        chk("mc_pending", 32'(pending), 32'hC1);
        // Re-request bit 7 on the handshake: ptr=6 picks 6, fixed would pick 7
        out_ready = 1'b1; req = 8'h80;
        tick(); req = '0;
        grant("mc1", 3'd6);
        tick(); grant("mc2", 3'd0);
        tick(); grant("mc3", 3'd7);
        tick();
        chk("mc_idle_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-BUSY
        mode = 1'b0; out_ready = 1'b0; req = 8'h20;
        tick(); req = '0;
        grant("rst_pre", 3'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_onehot", 32'(out_onehot), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
